// File: rtl/user_nmi_guard_pkg.sv
// user_nmi_guard_pkg
// Shared types and constants for the user NMI guard bridge:
//   state_t            - bridge FSM states (IDLE, REQ, RESP, ERR)
//   DEFAULT_ERR_RDATA  - read data returned on an aborted access
//   req_t              - registered core request {addr, wdata, wstrb}
//   addr_in_window()   - inclusive unsigned window check
// FLASH_START_ADDR falls back to 32'h3000_0000 when the build does not define it.

`ifndef FLASH_START_ADDR
`define FLASH_START_ADDR 32'h3000_0000
`endif

package user_nmi_guard_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        ERR
    } state_t;

    localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEAD_BEEF;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    // Bounds are passed as arguments so a full-range window does not
    // collapse into a constant comparison at the call site.
    function automatic logic addr_in_window(input logic [31:0] addr,
                                            input logic [31:0] lo,
                                            input logic [31:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/nmi_if.sv
// nmi_if
// Simple valid/ready memory request interface.
//   master: drives valid, addr, wdata, wstrb; receives ready, rdata
//   slave : receives valid, addr, wdata, wstrb; drives ready, rdata
// wstrb == 0 denotes a read.

interface nmi_if;
    logic        valid;
    logic        ready;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;

    modport master (
        output valid, addr, wdata, wstrb,
        input  ready, rdata
    );

    modport slave (
        input  valid, addr, wdata, wstrb,
        output ready, rdata
    );
endinterface

// File: rtl/user_nmi_guard_wdog.sv
// user_nmi_guard_wdog
// Loadable / clearable stall counter with an expire flag.
// Ports:
//   clk_i, rst_n_i  clock, synchronous active-low reset
//   clr_i           force count to 0 (highest priority)
//   load_i          load load_val_i (below clr_i)
//   load_val_i      value to load
//   inc_i           increment by one; saturates instead of wrapping
//   expire_o        count has reached TIMEOUT_CYC-1

module user_nmi_guard_wdog #(
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             inc_i,
    output logic             expire_o
);

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_reg <= '0;
        end else if (clr_i) begin
            cnt_reg <= '0;
        end else if (load_i) begin
            cnt_reg <= load_val_i;
        end else if (inc_i && (cnt_reg != CNT_SAT)) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign expire_o = (cnt_reg == CNT_LIMIT);

endmodule

// File: rtl/user_nmi_guard_bridge.sv
// user_nmi_guard_bridge
// Guards a user core's nmi_if master port: registers one request at a time,
// forwards it to the crossbar only if its address lies in [ADDR_LO, ADDR_HI],
// and aborts crossbar accesses that stall for TIMEOUT_CYC cycles. Aborted
// accesses complete locally with ERR_RDATA and record a sticky error.
// Ports:
//   clk_i, rst_n_i  clock, synchronous active-low reset
//   s               nmi_if.slave from the core
//   m               nmi_if.master to the crossbar
//   err_clr_i       clears err_o / err_addr_o / err_to_o (an error set wins)
//   err_o           sticky abort flag
//   err_addr_o      address of the most recent abort
//   err_to_o        1 = last abort was a timeout, 0 = illegal address
// Optional (macro USER_NMI_GUARD_PERF_EN):
//   perf_txn_o      completed legal transactions
//   perf_stall_o    REQ cycles with m.ready low

`ifndef FLASH_START_ADDR
`define FLASH_START_ADDR 32'h3000_0000
`endif

module user_nmi_guard_bridge
    import user_nmi_guard_pkg::*;
#(
    parameter logic [4:0]  ID          = 5'd31,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter logic [31:0] ADDR_LO     = `FLASH_START_ADDR,
    parameter logic [31:0] ADDR_HI     = 32'hFFFF_FFFF,
    parameter logic [31:0] ERR_RDATA   = DEFAULT_ERR_RDATA
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    nmi_if.slave        s,
    nmi_if.master       m,
    input  logic        err_clr_i,
    output logic        err_o,
    output logic [31:0] err_addr_o,
    output logic        err_to_o
`ifdef USER_NMI_GUARD_PERF_EN
    ,
    output logic [31:0] perf_txn_o,
    output logic [31:0] perf_stall_o
`endif
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    state_t      state_reg, state_next;
    req_t        req_reg;
    logic [31:0] rdata_reg;
    logic        err_phase_reg;
    logic        err_reg;
    logic [31:0] err_addr_reg;
    logic        err_to_reg;

    logic        wdog_expire;
    logic        stall;
    logic        enter_err;

    assign stall = (state_reg == REQ) && !m.ready;

    user_nmi_guard_wdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) u_wdog (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .clr_i      (state_reg != REQ),
        .load_i     (1'b0),
        .load_val_i ('0),
        .inc_i      (stall),
        .expire_o   (wdog_expire)
    );

    // ERR holds for two cycles so an illegal access answers at the same
    // point as the fastest legal one; s.ready pulses only in the second.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (s.valid) begin
                    state_next = addr_in_window(s.addr, ADDR_LO, ADDR_HI) ? REQ : ERR;
                end
            end
            REQ: begin
                // Ready beats the timeout when both happen in the same cycle.
                if (m.ready) begin
                    state_next = RESP;
                end else if (wdog_expire) begin
                    state_next = ERR;
                end
            end
            RESP:    state_next = IDLE;
            ERR:     state_next = err_phase_reg ? IDLE : ERR;
            default: state_next = IDLE;
        endcase
    end

    assign enter_err = (state_next == ERR) && (state_reg != ERR);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_reg     <= IDLE;
            req_reg       <= '0;
            rdata_reg     <= '0;
            err_phase_reg <= 1'b0;
            err_reg       <= 1'b0;
            err_addr_reg  <= '0;
            err_to_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            err_phase_reg <= (state_reg == ERR) && !err_phase_reg;

            if ((state_reg == IDLE) && s.valid) begin
                req_reg <= '{addr: s.addr, wdata: s.wdata, wstrb: s.wstrb};
            end

            if ((state_reg == REQ) && m.ready) begin
                rdata_reg <= m.rdata;
            end else if (enter_err) begin
                rdata_reg <= ERR_RDATA;
            end

            if (enter_err) begin
                err_reg      <= 1'b1;
                // An illegal request is rejected before req_reg is loaded.
                err_addr_reg <= (state_reg == IDLE) ? s.addr : req_reg.addr;
                err_to_reg   <= (state_reg == REQ);
            end else if (err_clr_i) begin
                err_reg      <= 1'b0;
                err_addr_reg <= '0;
                err_to_reg   <= 1'b0;
            end
        end
    end

    assign m.valid    = (state_reg == REQ);
    assign m.addr     = req_reg.addr;
    assign m.wdata    = req_reg.wdata;
    assign m.wstrb    = req_reg.wstrb;
    assign s.ready    = (state_reg == RESP) || ((state_reg == ERR) && err_phase_reg);
    assign s.rdata    = rdata_reg;
    assign err_o      = err_reg;
    assign err_addr_o = err_addr_reg;
    assign err_to_o   = err_to_reg;

`ifdef USER_NMI_GUARD_PERF_EN
    logic [31:0] perf_txn_reg;
    logic [31:0] perf_stall_reg;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || err_clr_i) begin
            perf_txn_reg   <= '0;
            perf_stall_reg <= '0;
        end else begin
            if ((state_reg == REQ) && m.ready) begin
                perf_txn_reg <= perf_txn_reg + 32'd1;
            end
            if (stall) begin
                perf_stall_reg <= perf_stall_reg + 32'd1;
            end
        end
    end

    assign perf_txn_o   = perf_txn_reg;
    assign perf_stall_o = perf_stall_reg;
`else
    // Performance counters not built.
`endif

endmodule

// File: tb/tb_user_nmi_guard_bridge.sv
// tb_user_nmi_guard_bridge
// Directed bench for user_nmi_guard_bridge with TIMEOUT_CYC=8 and
// ADDR_LO=0x3000_0000. Inputs change 1 time unit after the rising edge and
// outputs are checked at the same point.

module tb_user_nmi_guard_bridge;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        err_clr_i;
    logic        err_o;
    logic [31:0] err_addr_o;
    logic        err_to_o;
`ifdef USER_NMI_GUARD_PERF_EN
    logic [31:0] perf_txn_o;
    logic [31:0] perf_stall_o;
`endif

    nmi_if s_if ();
    nmi_if m_if ();

    int pass_cnt  = 0;
    int total_cnt = 0;
    int vcnt;

    always #5 clk_i = ~clk_i;

    user_nmi_guard_bridge #(
        .TIMEOUT_CYC (8),
        .ADDR_LO     (32'h3000_0000),
        .ADDR_HI     (32'hFFFF_FFFF),
        .ERR_RDATA   (32'hDEAD_BEEF)
    ) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .s            (s_if),
        .m            (m_if),
        .err_clr_i    (err_clr_i),
        .err_o        (err_o),
        .err_addr_o   (err_addr_o),
        .err_to_o     (err_to_o)
`ifdef USER_NMI_GUARD_PERF_EN
        ,
        .perf_txn_o   (perf_txn_o),
        .perf_stall_o (perf_stall_o)
`endif
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        $display("check %-22s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive_req(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
        s_if.valid = 1'b1;
        s_if.addr  = addr;
        s_if.wdata = wdata;
        s_if.wstrb = wstrb;
    endtask

    initial begin
        rst_n_i    = 1'b0;
        err_clr_i  = 1'b0;
        s_if.valid = 1'b0;
        s_if.addr  = '0;
        s_if.wdata = '0;
        s_if.wstrb = '0;
        m_if.ready = 1'b0;
        m_if.rdata = '0;

        // Reset state
        tick();
        tick();
        check("rst_m_valid",  m_if.valid, 0);
        check("rst_s_ready",  s_if.ready, 0);
        check("rst_s_rdata",  s_if.rdata, 0);
        check("rst_m_addr",   m_if.addr, 0);
        check("rst_m_wstrb",  m_if.wstrb, 0);
        check("rst_err",      err_o, 0);
        check("rst_err_addr", err_addr_o, 0);
        check("rst_err_to",   err_to_o, 0);
        rst_n_i = 1'b1;
        tick();

        // Legal read, crossbar ready in the second REQ cycle
        drive_req(32'h3000_0000, 32'h0, 4'h0);
        tick();
        check("rd_m_valid_p1", m_if.valid, 1);
        check("rd_m_addr",     m_if.addr, 32'h3000_0000);
        check("rd_m_wstrb",    m_if.wstrb, 0);
        check("rd_s_ready_p1", s_if.ready, 0);
        tick();
        check("rd_m_valid_p2", m_if.valid, 1);
        m_if.ready = 1'b1;
        m_if.rdata = 32'h1234_5678;
        tick();
        check("rd_s_ready",    s_if.ready, 1);
        check("rd_s_rdata",    s_if.rdata, 32'h1234_5678);
        check("rd_m_valid_rs", m_if.valid, 0);
        check("rd_err",        err_o, 0);
        m_if.ready = 1'b0;
        s_if.valid = 1'b0;
        tick();
        check("rd_s_ready_end", s_if.ready, 0);

        // Illegal write: never forwarded, answered at +2
        drive_req(32'h0000_0010, 32'h5555_AAAA, 4'hF);
        tick();
        check("ill_m_valid_p1", m_if.valid, 0);
        check("ill_s_ready_p1", s_if.ready, 0);
        tick();
        check("ill_m_valid_p2", m_if.valid, 0);
        check("ill_s_ready_p2", s_if.ready, 1);
        check("ill_s_rdata",    s_if.rdata, 32'hDEAD_BEEF);
        check("ill_err",        err_o, 1);
        check("ill_err_addr",   err_addr_o, 32'h0000_0010);
        check("ill_err_to",     err_to_o, 0);
        s_if.valid = 1'b0;
        tick();
        check("ill_s_ready_end", s_if.ready, 0);

        // err_clr clears the sticky record
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        check("clr_err",      err_o, 0);
        check("clr_err_addr", err_addr_o, 0);

        // Timeout: m.ready held low, m.valid must stay up exactly 8 cycles
        drive_req(32'h4000_0000, 32'h0, 4'h0);
        tick();
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (!m_if.valid) break;
            vcnt++;
            tick();
        end
        check("to_m_valid_cycles", vcnt, 8);
        check("to_s_ready_p1",     s_if.ready, 0);
        tick();
        check("to_s_ready",   s_if.ready, 1);
        check("to_s_rdata",   s_if.rdata, 32'hDEAD_BEEF);
        check("to_err",       err_o, 1);
        check("to_err_to",    err_to_o, 1);
        check("to_err_addr",  err_addr_o, 32'h4000_0000);
        s_if.valid = 1'b0;
        tick();

        // err_clr in the same cycle as an ERR entry: the set wins
        drive_req(32'h0000_0020, 32'h0, 4'h0);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        check("clrset_err",      err_o, 1);
        check("clrset_err_addr", err_addr_o, 32'h0000_0020);
        check("clrset_err_to",   err_to_o, 0);
        tick();
        check("clrset_s_ready",  s_if.ready, 1);
        s_if.valid = 1'b0;
        tick();

        // Clear, then timeout boundary: ready on the 8th REQ cycle
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        check("clr2_err",    err_o, 0);
        check("clr2_err_to", err_to_o, 0);
        drive_req(32'h5000_0000, 32'h0, 4'h0);
        tick();
        for (int i = 0; i < 7; i++) tick();
        check("bnd_m_valid_c8", m_if.valid, 1);
        m_if.ready = 1'b1;
        m_if.rdata = 32'hCAFE_F00D;
        tick();
        check("bnd_s_ready", s_if.ready, 1);
        check("bnd_s_rdata", s_if.rdata, 32'hCAFE_F00D);
        check("bnd_err",     err_o, 0);
        m_if.ready = 1'b0;
        s_if.valid = 1'b0;
        tick();
`ifdef USER_NMI_GUARD_PERF_EN
        check("bnd_perf_txn",   perf_txn_o, 1);
        check("bnd_perf_stall", perf_stall_o, 7);
`endif

        // Reset while in REQ
        drive_req(32'h6000_0000, 32'h0, 4'h0);
        tick();
        check("mrst_m_valid_req", m_if.valid, 1);
        rst_n_i    = 1'b0;
        s_if.valid = 1'b0;
        tick();
        check("mrst_m_valid", m_if.valid, 0);
        check("mrst_s_ready", s_if.ready, 0);
        rst_n_i = 1'b1;
        tick();
        check("mrst_s_ready_after", s_if.ready, 0);
        check("mrst_m_valid_after", m_if.valid, 0);

        // Back-to-back legal reads, each IDLE -> REQ -> RESP
        m_if.ready = 1'b1;
        m_if.rdata = 32'hAAAA_0001;
        drive_req(32'h7000_0000, 32'h0, 4'h0);
        tick();
        check("b2b0_m_valid", m_if.valid, 1);
        check("b2b0_s_ready_p1", s_if.ready, 0);
        tick();
        check("b2b0_s_ready", s_if.ready, 1);
        check("b2b0_s_rdata", s_if.rdata, 32'hAAAA_0001);
        s_if.valid = 1'b0;
        tick();
        drive_req(32'h7000_0004, 32'h0, 4'h0);
        m_if.rdata = 32'hBBBB_0002;
        tick();
        check("b2b1_m_addr", m_if.addr, 32'h7000_0004);
        check("b2b1_s_ready_p1", s_if.ready, 0);
        tick();
        check("b2b1_s_ready", s_if.ready, 1);
        check("b2b1_s_rdata", s_if.rdata, 32'hBBBB_0002);
        s_if.valid = 1'b0;
        m_if.ready = 1'b0;
        tick();
        check("b2b_s_ready_end", s_if.ready, 0);
        check("b2b_err", err_o, 0);
`ifdef USER_NMI_GUARD_PERF_EN
        check("b2b_perf_txn",   perf_txn_o, 2);
        check("b2b_perf_stall", perf_stall_o, 0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/user_nmi_guard_bridge.md
Name: user_nmi_guard_bridge

Overview:
- Downstream stage of a user core's `nmi_if` master port. Sits between `user_core_design` and the SoC NMI crossbar.
- Registers each core request (one outstanding) and checks the address against an allowed window.
- Forwards legal requests to the crossbar; a watchdog aborts any downstream access that stalls too long.
- Illegal or timed-out accesses are completed locally with an error read value, and a sticky error flag with the faulting address is recorded.

Parameters:
- ID, 5'd31: core slot ID; selects this bridge instance, no functional effect.
- TIMEOUT_CYC, 1024: cycles REQ may wait for m.ready before abort; legal range 1..65535.
- ADDR_LO, `FLASH_START_ADDR: inclusive lower bound of the legal window.
- ADDR_HI, 32'hFFFF_FFFF: inclusive upper bound of the legal window.
- ERR_RDATA, 32'hDEAD_BEEF: rdata returned on an aborted access.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  synchronous active-low reset
- s  nmi_if.slave  iface  from core (valid, ready, addr[31:0], wdata[31:0], wstrb[3:0], rdata[31:0])
- m  nmi_if.master  iface  to crossbar
- err_clr_i  in  1  clears err_o and err_addr_o
- err_o  out  1  sticky: an abort occurred
- err_addr_o  out  32  address of the most recent abort
- err_to_o  out  1  1 = last abort was a timeout, 0 = illegal address

Behaviour:
- One clock; reset is synchronous and active-low (rst_n_i, sampled on clk_i rising edge).
- Reset values:
  - state=IDLE, m.valid=0, s.ready=0, s.rdata=0.
  - m.addr/m.wdata=0, m.wstrb=0, counter=0.
  - err_o=0, err_addr_o=0, err_to_o=0.
- Reset asserted mid-transaction: the bridge returns to IDLE and drops m.valid the next cycle. No response is sent to the core.
- State machine (one-hot or enum from the package):
  - IDLE:
    - On s.valid, latch addr/wdata/wstrb into a request register.
    - ADDR_LO<=addr<=ADDR_HI (unsigned) -> REQ; otherwise -> ERR.
  - REQ:
    - m.valid=1 with the registered fields; the fields stay stable while m.valid is high.
    - Counter increments each cycle m.ready=0.
    - m.ready=1 -> capture m.rdata, go to RESP, clear the counter.
    - counter==TIMEOUT_CYC-1 with m.ready=0 -> ERR with err_to_o=1; m.valid drops the next cycle.
    - m.ready and timeout in the same cycle: m.ready wins (RESP).
  - RESP: s.ready=1 for exactly one cycle, s.rdata=captured data; -> IDLE.
  - ERR:
    - s.ready=1 for exactly one cycle, s.rdata=ERR_RDATA.
    - Set err_o=1 and err_addr_o=latched address.
    - err_to_o=1 for a timeout, 0 for an illegal address.
    - -> IDLE.
- Writes (wstrb!=0) to an illegal address are never forwarded; they complete via ERR with rdata=ERR_RDATA.
- s.ready is 0 in IDLE and REQ. The core drops s.valid after s.ready; IDLE samples a new request on the following cycle.
- Latency:
  - Legal access: s.valid -> m.valid at +1 cycle; m.ready -> s.ready at +1 cycle. Minimum 3 cycles total.
  - Illegal access: s.ready at +2 cycles.
- Counter width is $clog2(TIMEOUT_CYC+1); it never wraps.
- err_clr_i clears all three err outputs the next cycle. If an ERR-state set happens in the same cycle, the set wins.
- Only one transaction is outstanding at a time; no buffering beyond the request register.

Optional Feature:
- Macro: USER_NMI_GUARD_PERF_EN.
- Defined: adds outputs perf_txn_o[31:0] and perf_stall_o[31:0].
  - perf_txn_o counts completed legal transactions (RESP entries).
  - perf_stall_o counts REQ cycles with m.ready=0.
  - Both counters wrap modulo 2^32, reset to 0, and are cleared by err_clr_i.
- Undefined: the ports and logic are absent; the behaviour is otherwise identical.

Decomposition:
- Package user_nmi_guard_pkg holds:
  - state enum (IDLE, REQ, RESP, ERR);
  - default ERR_RDATA constant;
  - request struct {addr, wdata, wstrb}.
- One sub-module, user_nmi_guard_wdog: loadable/clearable timeout counter with an expire output. The bridge instantiates it once.

Test Plan:
- Read 0x3000_0000 (legal); crossbar ready after 2 cycles with rdata 0x1234_5678 -> m.valid at +1, s.ready one cycle, s.rdata=0x1234_5678, err_o=0.
- Write 0x0000_0010, wstrb 4'hF, ADDR_LO=0x3000_0000 -> m.valid never asserted; s.ready at +2; s.rdata=0xDEAD_BEEF; err_o=1, err_addr_o=0x0000_0010, err_to_o=0.
- TIMEOUT_CYC=8, legal read, m.ready held 0 -> m.valid high exactly 8 cycles then low; s.ready with 0xDEAD_BEEF; err_to_o=1.
- Timeout boundary: m.ready=1 on the 8th REQ cycle -> normal RESP with crossbar data; no error recorded.
- rst_n_i low while in REQ -> the next cycle has m.valid=0, state IDLE, no s.ready pulse; the following request completes normally.
- err_clr_i asserted in the same cycle as an ERR entry -> err_o stays 1. Back-to-back legal reads each complete in 3 cycles. With USER_NMI_GUARD_PERF_EN, perf_txn_o=2.
